// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - serial boot-frame loader that writes a checked program image into instruction memory
module imem_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_WORDS = 64
) (
    input  logic        clk0,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [5:0]  imem_addr,
    output logic [15:0] imem_wdata,
    output logic        core_rst_n,
    output logic        load_done,
    output logic        load_err
);
    typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHECK, DONE, ERR} state_t;

    localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

    state_t     state, state_nxt;
    logic [5:0] ptr, last_ptr;
    logic [7:0] acc, hi_byte;
    logic       accept, count_ok;

    assign rx_ready   = (state != DONE);
    assign core_rst_n = (state == DONE);
    assign load_done  = (state == DONE);
    assign load_err   = (state == ERR);
    assign accept     = rx_valid && rx_ready;
    assign count_ok   = (rx_data != 8'd0) && (rx_data <= MAX_N);

    always_ff @(posedge clk0) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                IDLE:    if (rx_data == SYNC_BYTE) state_nxt = COUNT;
                COUNT:   state_nxt = count_ok ? HI : ERR;
                HI:      state_nxt = LO;
                LO:      state_nxt = (ptr == last_ptr) ? CHECK : HI;
                CHECK:   state_nxt = (rx_data == acc) ? DONE : ERR;
                ERR:     if (rx_data == SYNC_BYTE) state_nxt = COUNT;
                default: state_nxt = state;
            endcase
        end
    end

    // Pointer stops at N-1 so the final word of a 64-word image never wraps the address.
    always_ff @(posedge clk0) begin
        if (!reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= 6'd0;
            imem_wdata <= 16'd0;
            ptr        <= 6'd0;
            last_ptr   <= 6'd0;
            acc        <= 8'd0;
            hi_byte    <= 8'd0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                case (state)
                    COUNT: begin
                        if (count_ok) begin
                            ptr      <= 6'd0;
                            acc      <= 8'd0;
                            last_ptr <= 6'(rx_data - 8'd1);
                        end
                    end
                    HI: begin
                        hi_byte <= rx_data;
                        acc     <= acc ^ rx_data;
                    end
                    LO: begin
                        acc        <= acc ^ rx_data;
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr;
                        imem_wdata <= {hi_byte, rx_data};
                        if (ptr != last_ptr) ptr <= ptr + 6'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - frame-vector table plus write scoreboard for imem_loader
module tb_imem_loader;
    logic        clk0 = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready, imem_we, core_rst_n, load_done, load_err;
    logic [5:0]  imem_addr;
    logic [15:0] imem_wdata;

    int compares = 0;
    int fails    = 0;
    logic [21:0] sb[$];

    imem_loader dut (
        .clk0(clk0), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst_n(core_rst_n),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk0 = ~clk0;

    typedef struct packed {
        logic [0:9][7:0] b;
        int              len;
        int              gap;
        int              d0;
        int              nw;
        logic            done;
        logic            err;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk0) begin
        if (imem_we === 1'b1) begin
            compares++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", imem_addr, imem_wdata);
            end else begin
                logic [21:0] e;
                e = sb.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    fails++;
                    $display("FAIL write actual=%0h:%0h required=%0h:%0h",
                             imem_addr, imem_wdata, e[21:16], e[15:0]);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk0); #1;
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk0); #1; end
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk0); #1;
        rx_valid = 1'b0;
    endtask

    task automatic check_flags(input string nm, input logic done, input logic err);
        chk({nm, "_done"}, 32'(load_done), 32'(done));
        chk({nm, "_err"}, 32'(load_err), 32'(err));
        chk({nm, "_core_rst_n"}, 32'(core_rst_n), 32'(done));
        chk({nm, "_rx_ready"}, 32'(rx_ready), 32'(!done));
    endtask

    task automatic drain(input string nm);
        repeat (2) begin @(posedge clk0); #1; end
        chk({nm, "_pending_writes"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run_vec(input int k, input logic do_rst);
        string nm;
        nm = $sformatf("vec%0d", k);
        if (do_rst) do_reset();
        for (int w = 0; w < vt[k].nw; w++)
            sb.push_back({6'(w), vt[k].b[vt[k].d0 + 2*w], vt[k].b[vt[k].d0 + 2*w + 1]});
        for (int i = 0; i < vt[k].len; i++) send_byte(vt[k].b[i], vt[k].gap);
        check_flags(nm, vt[k].done, vt[k].err);
        drain(nm);
    endtask

    initial begin
        logic [7:0] hb[64];
        logic [7:0] lb[64];
        logic [7:0] x;

        vt[0] = '{{8'hA5,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h40,8'h00,8'h00,8'h00}, 7, 0, 2, 2, 1'b1, 1'b0};
        vt[1] = '{{8'hA5,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h41,8'h00,8'h00,8'h00}, 7, 0, 2, 2, 1'b0, 1'b1};
        vt[2] = '{{8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 0, 2, 0, 1'b0, 1'b1};
        vt[3] = '{{8'hA5,8'h41,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 0, 2, 0, 1'b0, 1'b1};
        vt[4] = '{{8'h00,8'hFF,8'h5A,8'hA5,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h40}, 10, 0, 5, 2, 1'b1, 1'b0};
        vt[5] = '{{8'hA5,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h40,8'h00,8'h00,8'h00}, 7, 2, 2, 2, 1'b1, 1'b0};
        vt[6] = '{{8'hA5,8'h01,8'hFF,8'h00,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00}, 5, 0, 2, 1, 1'b1, 1'b0};
        vt[7] = '{{8'hA5,8'h03,8'h11,8'h22,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 4, 1, 2, 1, 1'b0, 1'b0};

        do_reset();
        check_flags("reset", 1'b0, 1'b0);
        chk("reset_we", 32'(imem_we), 32'd0);
        chk("reset_addr", 32'(imem_addr), 32'd0);
        chk("reset_wdata", 32'(imem_wdata), 32'd0);

        for (int k = 0; k < 8; k++) run_vec(k, 1'b1);

        // Junk alone must leave the loader idle
        do_reset();
        send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
        check_flags("junk_only", 1'b0, 1'b0);
        drain("junk_only");

        // Bad checksum, then a correct frame recovers without reset
        run_vec(1, 1'b1);
        run_vec(0, 1'b0);
        chk("hold_addr", 32'(imem_addr), 32'd1);
        chk("hold_wdata", 32'(imem_wdata), 32'hABCD);

        // Full-depth image
        do_reset();
        x = 8'd0;
        for (int w = 0; w < 64; w++) begin
            hb[w] = 8'($urandom_range(0, 255));
            lb[w] = 8'($urandom_range(0, 255));
            x = x ^ hb[w] ^ lb[w];
            sb.push_back({6'(w), hb[w], lb[w]});
        end
        send_byte(8'hA5, 0);
        send_byte(8'h40, 0);
        for (int w = 0; w < 64; w++) begin
            send_byte(hb[w], 0);
            send_byte(lb[w], 0);
        end
        send_byte(x, 0);
        check_flags("full64", 1'b1, 1'b0);
        chk("full64_last_addr", 32'(imem_addr), 32'd63);
        drain("full64");

        // Reset coinciding with the first low byte aborts the write
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h12, 0);
        rx_data = 8'h34;
        rx_valid = 1'b1;
        reset = 1'b0;
        @(posedge clk0); #1;
        rx_valid = 1'b0;
        reset = 1'b1;
        chk("midrst_we", 32'(imem_we), 32'd0);
        chk("midrst_addr", 32'(imem_addr), 32'd0);
        chk("midrst_wdata", 32'(imem_wdata), 32'd0);
        check_flags("midrst", 1'b0, 1'b0);
        drain("midrst");
        run_vec(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", compares, fails);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter MAX_WORDS, default 64, instruction memory depth in 16-bit words (6-bit address).
REQ-003 SHALL have port clk0  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port rx_valid  input  1  rx_data holds a byte.
REQ-006 SHALL have port rx_data  input  8  serial-receiver byte.
REQ-007 SHALL have port rx_ready  output  1  loader accepts a byte; a byte transfers when rx_valid && rx_ready.
REQ-008 SHALL have port imem_we  output  1  one-cycle write strobe to instruction memory, active-high.
REQ-009 SHALL have port imem_addr  output  6  write word address.
REQ-010 SHALL have port imem_wdata  output  16  write word.
REQ-011 SHALL have port core_rst_n  output  1  CPU core reset, active-low; low while loading.
REQ-012 SHALL have port load_done  output  1  image loaded and checksum verified.
REQ-013 SHALL have port load_err  output  1  frame error latched.

Function
REQ-014 Frame SHALL be: SYNC_BYTE, count byte N, then N words each high byte then low byte, then checksum byte equal to XOR of all 2N data bytes.
REQ-015 States SHALL be: IDLE, COUNT, HI, LO, CHECK, DONE, ERR.
REQ-016 IDLE: accepted byte == SYNC_BYTE -> COUNT; any other byte discarded, stay IDLE.
REQ-017 COUNT: N in 1..MAX_WORDS -> HI, word pointer = 0, checksum accumulator = 0; N == 0 or N > MAX_WORDS -> ERR.
REQ-018 HI: store byte as high byte, XOR into accumulator -> LO.
REQ-019 LO: XOR byte into accumulator; next cycle imem_we = 1 for exactly one cycle with imem_addr = word pointer and imem_wdata = {high, low}; pointer increments; -> HI if words written < N, else -> CHECK.
REQ-020 CHECK: byte == accumulator -> DONE; otherwise -> ERR.
REQ-021 DONE: load_done = 1, core_rst_n = 1, rx_ready = 0; stays until reset.
REQ-022 ERR: load_err = 1, core_rst_n = 0; accepted SYNC_BYTE clears load_err and -> COUNT; other bytes discarded.
REQ-023 rx_ready SHALL be 1 in every state except DONE; at most one byte accepted per cycle, so back-to-back valid bytes stream at one byte per cycle.
REQ-024 Word pointer SHALL never exceed N-1; address 63 is last legal write; no wrap occurs within a frame.
REQ-025 imem_addr and imem_wdata SHALL hold their last values when imem_we = 0.
REQ-026 core_rst_n SHALL be 0 in every state other than DONE.
REQ-027 A partial frame loads nothing further; words already written stay in memory and are overwritten by the next frame.

Reset
REQ-028 When reset == 0 at a clk0 edge: state = IDLE, imem_we = 0, imem_addr = 0, imem_wdata = 0, core_rst_n = 0, load_done = 0, load_err = 0, rx_ready = 1, pointer and accumulator = 0.
REQ-029 Reset SHALL take priority over any simultaneous byte transfer; a reset mid-frame aborts the frame with no further write strobe.

Verification
REQ-030 Frame A5,02,12,34,AB,CD,(12^34^AB^CD=40) back-to-back -> imem_we pulses at addr 0 data 16'h1234, at addr 1 data 16'hABCD; one cycle after checksum byte, load_done = 1, core_rst_n = 1, rx_ready = 0.
REQ-031 Same frame with checksum 41 -> both writes occur, then load_err = 1, core_rst_n stays 0, load_done stays 0; a following correct frame -> load_err clears, load_done = 1.
REQ-032 Count byte 00 or 41 -> ERR, no imem_we pulse.
REQ-033 Count 40 (64 words) -> 64 strobes, last at imem_addr 63, then DONE on correct checksum.
REQ-034 Junk bytes 00,FF,5A before A5 -> ignored, no state change; rx_valid gaps between bytes -> same writes as gapless stream.
REQ-035 reset = 0 for one cycle after the first LO byte is accepted -> no imem_we on the following cycle, all outputs at reset values, next A5 starts a fresh frame.
